// File: rtl/speedtest_pattern_source_64x32_pkg.sv
// Shared definitions for the speed-test pattern source.
// Holds the default geometry (vector width, memory depth, address width)
// and the playback FSM state type used by the top level.
package speedtest_pkg;

  localparam int SPEED_WIDTH  = 64;
  localparam int SPEED_DEPTH  = 32;
  localparam int SPEED_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pat_state_t;

endpackage

// File: rtl/speedtest_pattern_source_64x32_if.sv
// Host-side bus of the speed-test pattern source.
// Groups the pattern-memory write port, the playback controls and the
// vector/status outputs that feed the readout's Din input.
//   master : host / bench side (drives writes and controls, observes outputs)
//   slave  : pattern source side
interface speedtest_pattern_source_64x32_if
  import speedtest_pkg::*;
#(
  parameter int WIDTH  = SPEED_WIDTH,
  parameter int ADDR_W = SPEED_ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_rej;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W:0]   n_vectors;
  logic [7:0]        hold_cycles;
  logic [WIDTH-1:0]  Dout;
  logic              strobe;
  logic              busy;
  logic              done;
  logic              aborted;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_en, n_vectors, hold_cycles,
    input  wr_rej, Dout, strobe, busy, done, aborted
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_en, n_vectors, hold_cycles,
    output wr_rej, Dout, strobe, busy, done, aborted
  );

endinterface

// File: rtl/speedtest_pattern_source_64x32_ram.sv
// Pattern memory: DEPTH x WIDTH register file.
// Synchronous write, combinational read; contents are never reset.
// Ports:
//   clk     - write clock
//   wr_en   - write strobe (already gated by the controller)
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - combinational read data
module speedtest_pattern_ram
  import speedtest_pkg::*;
#(
  parameter int WIDTH  = SPEED_WIDTH,
  parameter int DEPTH  = SPEED_DEPTH,
  parameter int ADDR_W = SPEED_ADDR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/speedtest_pattern_source_64x32.sv
// Speed-test pattern source: stores up to DEPTH vectors and replays them onto
// a registered WIDTH-bit bus at a programmable hold rate, optionally looping.
// Ports:
//   CLK   - sole clock, rising edge
//   RESET - synchronous, active-high reset
//   bus   - slave side of speedtest_pattern_source_64x32_if:
//           wr_en/wr_addr/wr_data write port (idle only), wr_rej reject pulse,
//           start/stop/loop_en/n_vectors/hold_cycles playback controls,
//           Dout vector bus, strobe first-cycle marker, busy, done, aborted.
module speedtest_pattern_source_64x32
  import speedtest_pkg::*;
#(
  parameter int WIDTH  = SPEED_WIDTH,
  parameter int DEPTH  = SPEED_DEPTH,
  parameter int ADDR_W = SPEED_ADDR_W
) (
  input  logic CLK,
  input  logic RESET,
  speedtest_pattern_source_64x32_if.slave bus
);

  pat_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        hold_q, hold_d;
  logic [7:0]        h_q, h_d;
  logic              loop_q, loop_d;

  logic              load_vec;
  logic              strobe_d, done_d, aborted_d;
  logic              wr_accept;
  logic [WIDTH-1:0]  rd_data, vec_d;

  logic [WIDTH-1:0]  dout_p1;
  logic              strobe_p1, done_p1, aborted_p1, wr_rej_p1;

  // Index of the last vector to play; a request larger than the memory
  // plays the whole memory.
  function automatic logic [ADDR_W-1:0] last_index(input logic [ADDR_W:0] n);
    logic [ADDR_W:0] m;
    m = (n > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : n;
    m = m - (ADDR_W+1)'(1);
    return m[ADDR_W-1:0];
  endfunction

  assign wr_accept = bus.wr_en && (state_q == IDLE);

  speedtest_pattern_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (CLK),
    .wr_en   (wr_accept),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  // The RAM is read at the index about to be presented. A write landing in
  // the same cycle as start must already be visible, so bypass it.
  assign vec_d = (wr_accept && (bus.wr_addr == idx_d)) ? bus.wr_data : rd_data;

  // Next-state logic; priority in RUN is stop, then natural completion.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    last_d    = last_q;
    h_d       = h_q;
    loop_d    = loop_q;
    load_vec  = 1'b0;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.n_vectors != '0)) begin
          state_d  = RUN;
          idx_d    = '0;
          hold_d   = '0;
          last_d   = last_index(bus.n_vectors);
          h_d      = bus.hold_cycles;
          loop_d   = bus.loop_en;
          load_vec = 1'b1;
          strobe_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (hold_q == h_q) begin
          hold_d = '0;
          if (idx_q == last_q) begin
            if (loop_q) begin
              idx_d    = '0;
              load_vec = 1'b1;
              strobe_d = 1'b1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            idx_d    = idx_q + ADDR_W'(1);
            load_vec = 1'b1;
            strobe_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered FSM state and output bus.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hold_q      <= '0;
      last_q      <= '0;
      h_q         <= '0;
      loop_q      <= 1'b0;
      dout_p1     <= '0;
      strobe_p1   <= 1'b0;
      done_p1     <= 1'b0;
      aborted_p1  <= 1'b0;
      wr_rej_p1   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      last_q      <= last_d;
      h_q         <= h_d;
      loop_q      <= loop_d;
      strobe_p1   <= strobe_d;
      done_p1     <= done_d;
      aborted_p1  <= aborted_d;
      wr_rej_p1   <= bus.wr_en && (state_q == RUN);
      if (load_vec) begin
        dout_p1 <= vec_d;
      end
    end
  end

  assign bus.Dout    = dout_p1;
  assign bus.strobe  = strobe_p1;
  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_p1;
  assign bus.aborted = aborted_p1;
  assign bus.wr_rej  = wr_rej_p1;

endmodule

// File: tb/tb_speedtest_pattern_source_64x32.sv
// Directed bench for speedtest_pattern_source_64x32.
module tb_speedtest_pattern_source_64x32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] mem_m [32];

  speedtest_pattern_source_64x32_if #(.WIDTH(64), .ADDR_W(5)) bus ();

  speedtest_pattern_source_64x32 #(.WIDTH(64), .DEPTH(32), .ADDR_W(5)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int k);
    return {32'hA5A5_0000 + 32'(k), 32'(k)};
  endfunction

  task automatic write_vec(input int a, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    mem_m[a]    = d;
  endtask

  task automatic set_start(input int n, input int h, input logic l);
    bus.start       = 1'b1;
    bus.n_vectors   = 6'(n);
    bus.hold_cycles = 8'(h);
    bus.loop_en     = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.Dout !== 64'd0) begin errors++; $display("FAIL reset_dout got %h want 0", bus.Dout); end
    checks++; if (bus.strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", bus.strobe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", bus.aborted); end
    checks++; if (bus.wr_rej !== 1'b0) begin errors++; $display("FAIL reset_wr_rej got %b want 0", bus.wr_rej); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 4; k++) write_vec(k, pat(k));
    set_start(4, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.start = 1'b0;
      checks++; if (bus.Dout !== mem_m[k]) begin errors++; $display("FAIL basic_dout k=%0d got %h want %h", k, bus.Dout, mem_m[k]); end
      checks++; if (bus.strobe !== 1'b1) begin errors++; $display("FAIL basic_strobe k=%0d got %b want 1", k, bus.strobe); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy k=%0d got %b want 1", k, bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done k=%0d got %b want 0", k, bus.done); end
    end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", bus.busy); end
    checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted got %b want 0", bus.aborted); end
    checks++; if (bus.Dout !== mem_m[3]) begin errors++; $display("FAIL basic_dout_hold got %h want %h", bus.Dout, mem_m[3]); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_hold();
    set_start(2, 3, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      bus.start = 1'b0;
      checks++; if (bus.Dout !== mem_m[c/4]) begin errors++; $display("FAIL hold_dout c=%0d got %h want %h", c, bus.Dout, mem_m[c/4]); end
      checks++; if (bus.strobe !== ((c % 4) == 0)) begin errors++; $display("FAIL hold_strobe c=%0d got %b want %b", c, bus.strobe, (c % 4) == 0); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy c=%0d got %b want 1", c, bus.busy); end
    end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_done got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_loop_stop();
    set_start(3, 0, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick();
      bus.start = 1'b0;
      checks++; if (bus.Dout !== mem_m[c % 3]) begin errors++; $display("FAIL loop_dout c=%0d got %h want %h", c, bus.Dout, mem_m[c % 3]); end
      checks++; if (bus.strobe !== 1'b1) begin errors++; $display("FAIL loop_strobe c=%0d got %b want 1", c, bus.strobe); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL loop_early_done c=%0d got %b want 0", c, bus.done); end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stop_done got %b want 1", bus.done); end
    checks++; if (bus.aborted !== 1'b1) begin errors++; $display("FAIL stop_aborted got %b want 1", bus.aborted); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", bus.busy); end
    checks++; if (bus.Dout !== mem_m[0]) begin errors++; $display("FAIL stop_dout got %h want %h", bus.Dout, mem_m[0]); end
    tick();
    checks++; if (bus.aborted !== 1'b0) begin errors++; $display("FAIL stop_aborted_pulse got %b want 0", bus.aborted); end
    checks++; if (bus.Dout !== mem_m[0]) begin errors++; $display("FAIL stop_dout_keep got %h want %h", bus.Dout, mem_m[0]); end
  endtask

  task automatic test_wr_reject();
    int i;
    set_start(2, 1, 1'b0);
    tick();
    bus.start   = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.wr_en = 1'b0;
    checks++; if (bus.wr_rej !== 1'b1) begin errors++; $display("FAIL wr_rej_pulse got %b want 1", bus.wr_rej); end
    tick();
    checks++; if (bus.wr_rej !== 1'b0) begin errors++; $display("FAIL wr_rej_clear got %b want 0", bus.wr_rej); end
    i = 0;
    while (i < 10 && bus.done !== 1'b1) begin
      tick();
      i++;
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wr_rej_run_done got %b want 1 (timeout)", bus.done); end
    tick();
    set_start(1, 0, 1'b0);
    tick();
    bus.start = 1'b0;
    checks++; if (bus.Dout !== mem_m[0]) begin errors++; $display("FAIL wr_rej_replay got %h want %h", bus.Dout, mem_m[0]); end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL wr_rej_replay_done got %b want 1", bus.done); end
    tick();
  endtask

  task automatic test_same_cycle_write();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd0;
    bus.wr_data = 64'h0123_4567_89AB_CDEF;
    set_start(1, 0, 1'b0);
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    mem_m[0]  = 64'h0123_4567_89AB_CDEF;
    checks++; if (bus.Dout !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL same_cycle_write got %h want 0123456789abcdef", bus.Dout); end
    checks++; if (bus.wr_rej !== 1'b0) begin errors++; $display("FAIL same_cycle_wr_rej got %b want 0", bus.wr_rej); end
    tick(); tick();
  endtask

  task automatic test_n_zero();
    set_start(0, 0, 1'b0);
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nzero_busy got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL nzero_done got %b want 0", bus.done); end
    set_start(2, 0, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL start_stop_done got %b want 0", bus.done); end
  endtask

  task automatic test_clamp();
    for (int k = 0; k < 32; k++) write_vec(k, pat(k) ^ 64'h0000_5A00_0000_0000);
    set_start(40, 0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      tick();
      bus.start = 1'b0;
      checks++; if (bus.Dout !== mem_m[k] || bus.busy !== 1'b1) begin errors++; $display("FAIL clamp_dout k=%0d got %h busy %b want %h busy 1", k, bus.Dout, bus.busy, mem_m[k]); end
    end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clamp_done got %b want 1", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clamp_busy_end got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    set_start(4, 2, 1'b0);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.Dout !== 64'd0) begin errors++; $display("FAIL midreset_dout got %h want 0", bus.Dout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done_late got %b want 0", bus.done); end
    set_start(2, 0, 1'b0);
    tick();
    bus.start = 1'b0;
    checks++; if (bus.Dout !== mem_m[0]) begin errors++; $display("FAIL midreset_restart_v0 got %h want %h", bus.Dout, mem_m[0]); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midreset_restart_busy got %b want 1", bus.busy); end
    tick();
    checks++; if (bus.Dout !== mem_m[1]) begin errors++; $display("FAIL midreset_restart_v1 got %h want %h", bus.Dout, mem_m[1]); end
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL midreset_restart_done got %b want 1", bus.done); end
    tick();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.loop_en     = 1'b0;
    bus.n_vectors   = '0;
    bus.hold_cycles = '0;
    test_reset();
    test_basic();
    test_hold();
    test_loop_stop();
    test_wr_reject();
    test_same_cycle_write();
    test_n_zero();
    test_clamp();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
